// File: rtl/booth_pkg.sv
// -----------------------------------------------------------------------------
// booth_pkg
// Shared types and sizing helpers for the iterative radix-4 Booth multiplier.
//   state_e      : control FSM states (IDLE, BUSY, DONE)
//   digit_e      : decoded radix-4 Booth digit
//   calc_ng      : number of Booth groups for a given operand width
//   calc_iter    : BUSY cycles needed for a given width and digits-per-cycle
//   decode_digit : triplet (b[2i+1], b[2i], b[2i-1]) -> Booth digit
// -----------------------------------------------------------------------------
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    D_ZERO = 3'd0,
    D_POS1 = 3'd1,
    D_POS2 = 3'd2,
    D_NEG1 = 3'd3,
    D_NEG2 = 3'd4
  } digit_e;

  // One group more than WIDTH/2 so that an unsigned operand with its top bit
  // set still ends in a non-negative digit.
  function automatic int calc_ng(input int width);
    return width / 2 + 1;
  endfunction

  function automatic int calc_iter(input int width, input int pp);
    return (calc_ng(width) + pp - 1) / pp;
  endfunction

  function automatic digit_e decode_digit(input logic [2:0] trip);
    digit_e d;
    case (trip)
      3'b001, 3'b010: d = D_POS1;
      3'b011:         d = D_POS2;
      3'b100:         d = D_NEG2;
      3'b101, 3'b110: d = D_NEG1;
      default:        d = D_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// -----------------------------------------------------------------------------
// booth_pp_gen
// Combinational radix-4 Booth partial-product selector.
//   triplet_i [2:0]       : multiplier bits (b[2i+1], b[2i], b[2i-1])
//   mcand_i   [2*WIDTH-1] : multiplicand, already extended to 2*WIDTH bits
//   pp_o      [2*WIDTH-1] : selected multiple, one's-complemented if negative
//   neg_o                 : 1 when pp_o is a one's complement; the caller adds
//                           it as a carry at the digit's bit position
// -----------------------------------------------------------------------------
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]         triplet_i,
  input  logic [2*WIDTH-1:0] mcand_i,
  output logic [2*WIDTH-1:0] pp_o,
  output logic               neg_o
);

  digit_e digit;

  always_comb begin
    digit = decode_digit(triplet_i);
    pp_o  = '0;
    neg_o = 1'b0;
    case (digit)
      D_POS1: pp_o = mcand_i;
      D_POS2: pp_o = mcand_i << 1;
      D_NEG1: begin
        pp_o  = ~mcand_i;
        neg_o = 1'b1;
      end
      D_NEG2: begin
        pp_o  = ~(mcand_i << 1);
        neg_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/booth_mul_seq.sv
// -----------------------------------------------------------------------------
// booth_mul_seq
// Iterative radix-4 Booth multiplier, PP_PER_CYCLE digits accumulated per cycle.
//   clk, rst         : clock, synchronous active-high reset
//   in_valid/in_ready: operand handshake (accepted only in IDLE)
//   signed_mode      : 1 = two's-complement operands, 0 = unsigned
//   a, b             : multiplicand, multiplier (WIDTH bits)
//   out_valid/out_ready : product handshake (held in DONE until accepted)
//   product          : exact 2*WIDTH-bit product
// -----------------------------------------------------------------------------
module booth_mul_seq
  import booth_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int PP_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int ITER = calc_iter(WIDTH, PP_PER_CYCLE);
  localparam int PW   = 2 * WIDTH;
  // Multiplier is extended so every cycle has a full set of PP triplets.
  localparam int BLEN = 2 * ITER * PP_PER_CYCLE;
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  state_e          state_q,  state_d;
  logic [CW-1:0]   cnt_q,    cnt_d;
  logic [PW-1:0]   mcand_q,  mcand_d;
  // Bit 0 is the implicit b[-1]; the register shifts right by 2*PP per cycle,
  // so the current digits always sit at the bottom.
  logic [BLEN:0]   mplier_q, mplier_d;
  logic [PW-1:0]   acc_q,    acc_d;
  logic [PW-1:0]   prod_q,   prod_d;
  logic            ov_q,     ov_d;

  logic [PW-1:0]   pp_raw     [PP_PER_CYCLE];
  logic            pp_neg     [PP_PER_CYCLE];
  logic [PW-1:0]   pp_aligned [PP_PER_CYCLE];
  logic [PW-1:0]   pp_carry   [PP_PER_CYCLE];
  logic [PW-1:0]   step_sum;

  logic            a_ext_bit;
  logic            b_ext_bit;

  assign a_ext_bit = signed_mode & a[WIDTH-1];
  assign b_ext_bit = signed_mode & b[WIDTH-1];

  // The multiplicand register is pre-shifted by 2*PP each cycle, so within a
  // cycle digit gi only needs a constant offset of 2*gi.
  for (genvar gi = 0; gi < PP_PER_CYCLE; gi++) begin : g_pp
    booth_pp_gen #(
      .WIDTH(WIDTH)
    ) u_pp_gen (
      .triplet_i(mplier_q[2*gi+2 : 2*gi]),
      .mcand_i  (mcand_q),
      .pp_o     (pp_raw[gi]),
      .neg_o    (pp_neg[gi])
    );

    // (~x << s) + (1 << s) == -(x << s), so the negate carry lands at bit 2*gi.
    assign pp_aligned[gi] = pp_raw[gi] << (2 * gi);
    assign pp_carry[gi]   = PW'(pp_neg[gi]) << (2 * gi);
  end

  always_comb begin
    step_sum = acc_q;
    for (int p = 0; p < PP_PER_CYCLE; p++) begin
      step_sum = step_sum + pp_aligned[p] + pp_carry[p];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    ov_d     = ov_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = {{WIDTH{a_ext_bit}}, a};
          mplier_d = {{(BLEN - WIDTH){b_ext_bit}}, b, 1'b0};
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        acc_d    = step_sum;
        mcand_d  = mcand_q << (2 * PP_PER_CYCLE);
        mplier_d = mplier_q >> (2 * PP_PER_CYCLE);
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          prod_d  = step_sum;
          ov_d    = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          ov_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      ov_q     <= ov_d;
    end
  end

  assign in_ready  = (state_q == IDLE) & ~rst;
  assign out_valid = ov_q;
  assign product   = prod_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_booth_mul_seq
// Scoreboard bench: drivers push expected products when an operand pair is
// accepted; monitors pop and compare whenever a product is handed off.
// One WIDTH=32/PP=1 instance plus WIDTH=8 instances with PP=2 and PP=4.
// -----------------------------------------------------------------------------
module tb_booth_mul_seq;

  typedef struct packed {
    logic        sm;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec32_t;

  typedef struct packed {
    logic        sm;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec8_t;

  localparam int ITER32 = 17;

  logic clk;
  int   checks;
  int   errors;
  int   cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  // ---------------- WIDTH=32, PP=1 instance ----------------
  logic        rst;
  logic        in_valid32;
  logic        in_ready32;
  logic        sm32;
  logic [31:0] a32;
  logic [31:0] b32;
  logic        out_valid32;
  logic        out_ready32;
  logic [63:0] product32;
  logic [63:0] q32[$];

  booth_mul_seq #(
    .WIDTH(32),
    .PP_PER_CYCLE(1)
  ) u_dut32 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid32),
    .in_ready   (in_ready32),
    .signed_mode(sm32),
    .a          (a32),
    .b          (b32),
    .out_valid  (out_valid32),
    .out_ready  (out_ready32),
    .product    (product32)
  );

  // Monitor for the 32-bit instance.
  initial begin
    int          acc_edge;
    logic        ov_prev;
    logic [63:0] want;
    acc_edge = 0;
    ov_prev  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ov_prev = 1'b0;
      end else begin
        if (in_valid32 && in_ready32) acc_edge = cyc + 1;
        if (out_valid32 && !ov_prev) chk("lat32", 64'(cyc - acc_edge), 64'(ITER32));
        if (out_valid32 && out_ready32) begin
          if (q32.size() == 0) begin
            chk("spurious32", 64'(out_valid32), 64'd0);
          end else begin
            want = q32.pop_front();
            chk("prod32", product32, want);
            $display("W32 product %h expected %h", product32, want);
          end
        end
        ov_prev = out_valid32;
      end
    end
  end

  task automatic issue32(input logic sm, input logic [31:0] av, input logic [31:0] bv,
                         input logic [63:0] exp);
    int n;
    sm32       = sm;
    a32        = av;
    b32        = bv;
    in_valid32 = 1'b1;
    n = 0;
    while (!in_ready32 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ready32_timeout", 64'(in_ready32), 64'd1);
    if (in_ready32) q32.push_back(exp);
    @(posedge clk);
    #1;
    in_valid32 = 1'b0;
  endtask

  task automatic drain32();
    int n;
    n = 0;
    while (q32.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    chk("drain32", 64'(q32.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- WIDTH=8 instances, PP=2 and PP=4 ----------------
  logic rst8;

  for (genvar gi = 0; gi < 2; gi++) begin : g8
    localparam int PP   = (gi == 0) ? 2 : 4;
    localparam int ITER = (gi == 0) ? 3 : 2;

    logic        iv;
    logic        ir;
    logic        sm;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        ov;
    logic        ordy;
    logic [15:0] prod;
    logic [15:0] sb[$];
    logic        done;

    booth_mul_seq #(
      .WIDTH(8),
      .PP_PER_CYCLE(PP)
    ) u_dut8 (
      .clk        (clk),
      .rst        (rst8),
      .in_valid   (iv),
      .in_ready   (ir),
      .signed_mode(sm),
      .a          (a),
      .b          (b),
      .out_valid  (ov),
      .out_ready  (ordy),
      .product    (prod)
    );

    // Random backpressure on the product port.
    initial begin
      ordy = 1'b1;
      forever begin
        @(posedge clk);
        #1;
        ordy = ($urandom_range(0, 3) != 0);
      end
    end

    // Driver: hand-computed vectors, then a corner-value cross product.
    initial begin
      vec8_t      vq[$];
      vec8_t      dir[6];
      vec8_t      v;
      logic [7:0] vals[12];
      int         ai;
      int         bi;
      int         n;
      done = 1'b0;
      iv   = 1'b0;
      sm   = 1'b0;
      a    = '0;
      b    = '0;
      dir[0] = '{1'b1, 8'h80, 8'h80, 16'h4000};
      dir[1] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
      dir[2] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
      dir[3] = '{1'b1, 8'h80, 8'h7F, 16'hC080};
      dir[4] = '{1'b0, 8'h80, 8'hFF, 16'h7F80};
      dir[5] = '{1'b1, 8'hFD, 8'h07, 16'hFFEB};
      vals = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h7F, 8'h80,
               8'h81, 8'hFE, 8'hFF, 8'h55, 8'hAA, 8'h0C};
      for (int k = 0; k < 6; k++) vq.push_back(dir[k]);
      for (int s = 0; s < 2; s++) begin
        for (int i = 0; i < 12; i++) begin
          for (int j = 0; j < 12; j++) begin
            ai = (s == 1) ? int'($signed(vals[i])) : int'(vals[i]);
            bi = (s == 1) ? int'($signed(vals[j])) : int'(vals[j]);
            v.sm = s[0];
            v.a  = vals[i];
            v.b  = vals[j];
            v.p  = 16'(ai * bi);
            vq.push_back(v);
          end
        end
      end
      n = 0;
      while (rst8 && n < 100) begin
        @(posedge clk);
        n++;
      end
      #1;
      for (int k = 0; k < vq.size(); k++) begin
        sm = vq[k].sm;
        a  = vq[k].a;
        b  = vq[k].b;
        iv = 1'b1;
        n  = 0;
        while (!ir && n < 100) begin
          @(posedge clk);
          #1;
          n++;
        end
        if (!ir) chk($sformatf("ready8_pp%0d_timeout", PP), 64'(ir), 64'd1);
        else sb.push_back(vq[k].p);
        @(posedge clk);
        #1;
        iv = 1'b0;
      end
      n = 0;
      while (sb.size() != 0 && n < 1000) begin
        @(posedge clk);
        n++;
      end
      chk($sformatf("drain8_pp%0d", PP), 64'(sb.size()), 64'd0);
      done = 1'b1;
    end

    // Monitor.
    initial begin
      int          acc_edge;
      logic        ov_prev;
      logic [15:0] want;
      acc_edge = 0;
      ov_prev  = 1'b0;
      forever begin
        @(negedge clk);
        if (rst8) begin
          ov_prev = 1'b0;
        end else begin
          if (iv && ir) acc_edge = cyc + 1;
          if (ov && !ov_prev) chk($sformatf("lat8_pp%0d", PP), 64'(cyc - acc_edge), 64'(ITER));
          if (ov && ordy) begin
            if (sb.size() == 0) begin
              chk($sformatf("spurious8_pp%0d", PP), 64'(ov), 64'd0);
            end else begin
              want = sb.pop_front();
              chk($sformatf("prod8_pp%0d", PP), 64'(prod), 64'(want));
              $display("W8 pp%0d product %h expected %h", PP, prod, want);
            end
          end
          ov_prev = ov;
        end
      end
    end
  end

  // ---------------- Main sequence ----------------
  initial begin
    vec32_t t32[12];
    int     n;
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    rst8        = 1'b1;
    in_valid32  = 1'b0;
    out_ready32 = 1'b1;
    sm32        = 1'b0;
    a32         = '0;
    b32         = '0;

    t32[0]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
    t32[1]  = '{1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
    t32[2]  = '{1'b1, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB};
    t32[3]  = '{1'b0, 32'hFFFFFFFD, 32'h00000007, 64'h00000006_FFFFFFEB};
    t32[4]  = '{1'b1, 32'h00000000, 32'h12345678, 64'h00000000_00000000};
    t32[5]  = '{1'b0, 32'h80000001, 32'h00000001, 64'h00000000_80000001};
    t32[6]  = '{1'b1, 32'h80000001, 32'h00000001, 64'hFFFFFFFF_80000001};
    t32[7]  = '{1'b1, 32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000};
    t32[8]  = '{1'b0, 32'hFFFFFFFF, 32'h00000002, 64'h00000001_FFFFFFFE};
    t32[9]  = '{1'b1, 32'hFFFFFFFF, 32'h00000002, 64'hFFFFFFFF_FFFFFFFE};
    t32[10] = '{1'b0, 32'h12345678, 32'h00000010, 64'h00000001_23456780};
    t32[11] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid32), 64'd0);
    chk("rst_product", product32, 64'd0);
    chk("rst_in_ready", 64'(in_ready32), 64'd0);
    rst  = 1'b0;
    rst8 = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready32), 64'd1);

    // Back-to-back issue: each call holds in_valid through the previous op.
    for (int k = 0; k < 12; k++) issue32(t32[k].sm, t32[k].a, t32[k].b, t32[k].p);
    drain32();

    // Backpressure in DONE.
    out_ready32 = 1'b0;
    issue32(1'b0, 32'h00010000, 32'h00010000, 64'h00000001_00000000);
    n = 0;
    while (!out_valid32 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid32), 64'd1);
      chk("bp_product", product32, 64'h00000001_00000000);
      chk("bp_in_ready", 64'(in_ready32), 64'd0);
    end
    @(posedge clk);
    #1;
    out_ready32 = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_idle_in_ready", 64'(in_ready32), 64'd1);
    chk("bp_out_valid_clr", 64'(out_valid32), 64'd0);
    chk("bp_product_hold", product32, 64'h00000001_00000000);

    // Operand changes after acceptance are ignored.
    issue32(1'b1, 32'hFFFFFFF0, 32'hFFFFFFFD, 64'h00000000_00000030);
    a32  = 32'hDEADBEEF;
    b32  = 32'h0BADF00D;
    sm32 = 1'b0;
    drain32();

    // Reset during the 8th BUSY cycle aborts the operation.
    issue32(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    q32.delete();
    @(posedge clk);
    #1;
    chk("abort_out_valid", 64'(out_valid32), 64'd0);
    chk("abort_product", product32, 64'd0);
    chk("abort_in_ready", 64'(in_ready32), 64'd0);
    rst = 1'b0;
    #1;
    chk("abort_in_ready_after", 64'(in_ready32), 64'd1);
    issue32(1'b1, 32'd6, 32'd7, 64'd42);
    drain32();

    n = 0;
    while (!(g8[0].done && g8[1].done) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    chk("w8_done", 64'(g8[0].done && g8[1].done), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
